// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// Two-requester front end for a single shared combinational ALU.
// One operation in flight: accept in IDLE, drive the ALU in EXEC, hold the response in RESP.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // reqN_ready depends on reqN_valid; valid never depends on ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_MAX = 3'd4;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               id_q, id_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   src_a_q, src_a_d;
  logic [WIDTH-1:0]   src_b_q, src_b_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic               rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic               grant1;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [2:0]         sel_op;
  logic               sel_legal;

  // On a tie, round-robin hands the grant to whoever did not win last time.
  always_comb begin
    grant1 = 1'b0;
    if (req1_valid && !req0_valid) begin
      grant1 = 1'b1;
    end else if (req0_valid && req1_valid && RR_EN && !last_grant_q) begin
      grant1 = 1'b1;
    end
  end

  assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant1;
  assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant1;

  assign sel_a     = grant1 ? req1_a  : req0_a;
  assign sel_b     = grant1 ? req1_b  : req0_b;
  assign sel_op    = grant1 ? req1_op : req0_op;
  assign sel_legal = (sel_op <= OP_MAX);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    err_d        = err_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    ctrl_d       = ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d      = EXEC;
          last_grant_d = grant1;
          id_d         = grant1;
          err_d        = !sel_legal;
          // An illegal op never reaches the ALU; it only produces an error response.
          ctrl_d       = sel_legal ? sel_op : 3'd0;
          src_a_d      = sel_legal ? sel_a  : '0;
          src_b_d      = sel_legal ? sel_b  : '0;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = err_q;
        rsp_data_d  = err_q ? '0 : alu_result;
        ctrl_d      = 3'd0;
        src_a_d     = '0;
        src_b_d     = '0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        ctrl_d      = 3'd0;
        src_a_d     = '0;
        src_b_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      ctrl_q       <= 3'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      err_q        <= err_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      ctrl_q       <= ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // ALU operand registers are nonzero only while in EXEC.
  assign alu_src_a = src_a_q;
  assign alu_src_b = src_b_q;
  assign alu_ctrl  = ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// Bench for alu_arbiter: directed scenarios followed by random traffic, all checked by one
// negedge monitor against a transaction-level model (grant rule, expected result queue, latency).
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, rsp_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
  logic [W-1:0] alu_src_a, alu_src_b, alu_result, rsp_data;
  logic [2:0]   alu_ctrl;
  logic [1:0]   dbg_state;

  logic         fp_r0, fp_r1, fp_rsp_valid, fp_rsp_id, fp_rsp_err;
  logic [W-1:0] fp_src_a, fp_src_b, fp_alu_result, fp_rsp_data;
  logic [2:0]   fp_ctrl;
  logic [1:0]   fp_dbg_state;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  assign alu_result    = ref_alu(alu_ctrl, alu_src_a, alu_src_b);
  assign fp_alu_result = ref_alu(fp_ctrl, fp_src_a, fp_src_b);

  alu_arbiter #(.WIDTH(W), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  alu_arbiter #(.WIDTH(W), .RR_EN(1'b0)) fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_r0), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(fp_r1), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .alu_src_a(fp_src_a), .alu_src_b(fp_src_b), .alu_ctrl(fp_ctrl), .alu_result(fp_alu_result),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data),
    .rsp_err(fp_rsp_err), .dbg_state(fp_dbg_state)
  );

  // ---------------- scoreboard / model state (written only by the monitor) ----------------
  logic [W+1:0] exp_q[$];
  int           acc_q[$];
  int           n_vec = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           ex_cyc = -10;
  logic [2:0]   ex_ctrl;
  logic [W-1:0] ex_a, ex_b;
  logic         ex_legal;
  logic         m_busy = 1'b0;
  logic         m_last = 1'b1;
  logic         seen = 1'b0;
  int           hs_cnt0 = 0;
  int           hs_cnt1 = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, where the preceding posedge has settled.
  always @(negedge clk) begin
    logic         exp_g;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         err;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
      seen   = 1'b0;
      ex_cyc = -10;
      check("rst_ctl", 64'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err}), 64'd0);
      check("rst_data", 64'(rsp_data), 64'd0);
      check("rst_alu", 64'({alu_ctrl, alu_src_a, alu_src_b}), 64'd0);
    end else begin
      check("ready_excl", 64'(req0_ready & req1_ready), 64'd0);
      if (m_busy) begin
        check("ready_busy", 64'(req0_ready | req1_ready), 64'd0);
      end else if (req0_valid || req1_valid) begin
        exp_g = (req0_valid && req1_valid) ? !m_last : req1_valid;
        check("grant", 64'({req1_ready, req0_ready}), exp_g ? 64'd2 : 64'd1);
        if (req0_ready || req1_ready) begin
          op  = exp_g ? req1_op : req0_op;
          a   = exp_g ? req1_a  : req0_a;
          b   = exp_g ? req1_b  : req0_b;
          err = (op > 3'd4);
          exp_q.push_back({exp_g, err, err ? W'(0) : ref_alu(op, a, b)});
          acc_q.push_back(cyc);
          m_last   = exp_g;
          m_busy   = 1'b1;
          ex_cyc   = cyc + 1;
          ex_ctrl  = err ? 3'd0 : op;
          ex_a     = a;
          ex_b     = b;
          ex_legal = !err;
          if (exp_g) hs_cnt1++;
          else       hs_cnt0++;
        end
      end
      if (cyc == ex_cyc) begin
        check("exec_ctrl", 64'(alu_ctrl), 64'(ex_ctrl));
        if (ex_legal) check("exec_src", 64'({alu_src_a, alu_src_b}), {ex_a, ex_b});
      end else begin
        check("alu_idle", 64'({alu_ctrl, alu_src_a, alu_src_b}), 64'd0);
      end
      if (req0_valid && req1_valid && (fp_r0 || fp_r1))
        check("fixed_prio", 64'({fp_r1, fp_r0}), 64'd1);
      if (exp_q.size() == 0) begin
        check("rsp_spurious", 64'(rsp_valid), 64'd0);
      end else if (rsp_valid) begin
        if (!seen) begin
          check("rsp_latency", 64'(cyc - acc_q[0]), 64'd2);
          seen = 1'b1;
        end
        check("rsp", 64'({rsp_id, rsp_err, rsp_data}), 64'(exp_q[0]));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          seen   = 1'b0;
          m_busy = 1'b0;
        end
      end else if (cyc - acc_q[0] >= 2) begin
        check("rsp_missing", 64'(rsp_valid), 64'd1);
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        seen   = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive0(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    return ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 15));
  endfunction

  task automatic wait_hs1(input int max_cyc);
    int base;
    base = hs_cnt1;
    for (int i = 0; i < max_cyc && hs_cnt1 == base; i++) step();
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0 && !m_busy) break;
      step();
    end
  endtask

  initial begin
    int seen0, seen1;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = '0; req1_b = '0;

    // Single add held across reset release: accepted in the first cycle out of reset.
    drive0(3'd0, 32'd5, 32'd7);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    req0_valid = 1'b0;
    drain();

    // Tie from fresh reset: expect grants 0,1,0,1 (fixed-priority copy always picks 0).
    rst_n = 1'b0;
    drive0(3'd0, 32'd100, 32'd23);
    drive1(3'd3, 32'h0f0, 32'h00f);
    step(); step();
    rst_n = 1'b1;
    repeat (12) step();
    drain();

    // Backpressure on a sub response while req1 (slt) waits.
    rsp_ready = 1'b0;
    drive0(3'd1, 32'd3, 32'd9);
    step();
    req0_valid = 1'b0;
    drive1(3'd4, 32'd3, 32'd9);
    repeat (7) step();
    rsp_ready = 1'b1;
    wait_hs1(10);
    req1_valid = 1'b0;
    drain();

    // Illegal op on req1.
    drive1(3'd6, rnd_operand(), rnd_operand());
    wait_hs1(10);
    req1_valid = 1'b0;
    drain();

    // Reset in the middle of EXEC for a sub; nothing may come out afterwards.
    drive0(3'd1, 32'd40, 32'd2);
    step();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();

    // Random traffic with occasional withdrawals and response backpressure.
    seen0 = hs_cnt0;
    seen1 = hs_cnt1;
    repeat (400) begin
      if (hs_cnt0 != seen0) begin
        seen0 = hs_cnt0;
        drive0(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
        req0_valid = 1'($urandom_range(0, 1));
      end else if (!req0_valid) begin
        if ($urandom_range(0, 1) == 1) drive0(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
      end else if ($urandom_range(0, 19) == 0) begin
        req0_valid = 1'b0;
      end
      if (hs_cnt1 != seen1) begin
        seen1 = hs_cnt1;
        drive1(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
        req1_valid = 1'($urandom_range(0, 1));
      end else if (!req1_valid) begin
        if ($urandom_range(0, 1) == 1) drive1(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
      end else if ($urandom_range(0, 19) == 0) begin
        req1_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
